// File: rtl/pc_gen.sv
// Program counter / next-PC generator for the toothless fetch stage.
// Handles reset vector, compressed stepping, stall, trap/mret redirect, misalignment and halt.
module pc_gen #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR = '0,
    parameter int unsigned            C_EXT      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            ctrl_trans_instr_i,
    input  logic                  instr_len_i,
    input  logic [ADDR_WIDTH-1:0] offset_i,
    input  logic                  branch_tkn_i,
    input  logic [ADDR_WIDTH-1:0] tgt_addr_i,
    input  logic                  trap_i,
    input  logic [ADDR_WIDTH-1:0] trap_vec_i,
    input  logic                  mret_i,
    input  logic [ADDR_WIDTH-1:0] epc_i,
    input  logic                  stall_i,
    input  logic                  halt_i,
    input  logic                  resume_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus_o,
    output logic                  pc_valid_o,
    output logic                  misaligned_o,
    output logic [ADDR_WIDTH-1:0] misaligned_addr_o,
    output logic                  halted_o
);

    typedef enum logic [1:0] {
        CTRL_TRANS_SEL_NONE   = 2'b00,
        CTRL_TRANS_SEL_JUMP   = 2'b01,
        CTRL_TRANS_SEL_BRANCH = 2'b10
    } ctrl_sel_t;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic                  mis_pulse, mis_pulse_next;
    logic [ADDR_WIDTH-1:0] mis_addr, mis_addr_next;

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] pc_plus;
    logic [ADDR_WIDTH-1:0] trap_tgt;
    logic [ADDR_WIDTH-1:0] jump_tgt;
    logic [ADDR_WIDTH-1:0] branch_tgt;
    logic [ADDR_WIDTH-1:0] cand;
    logic                  cand_checked;
    logic                  advance;
    logic                  cand_misaligned;
    logic                  is_jump;
    logic                  is_branch;

    assign step       = ((C_EXT != 0) && instr_len_i) ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);
    assign pc_plus    = pc + step;
    assign trap_tgt   = {trap_vec_i[ADDR_WIDTH-1:2], 2'b00};
    assign jump_tgt   = {tgt_addr_i[ADDR_WIDTH-1:1], 1'b0};
    assign branch_tgt = pc + {offset_i[ADDR_WIDTH-1:1], 1'b0};

    assign is_jump    = (ctrl_trans_instr_i == CTRL_TRANS_SEL_JUMP);
    assign is_branch  = (ctrl_trans_instr_i == CTRL_TRANS_SEL_BRANCH);

    // Candidate for the non-trap update; mret bypasses stall, the rest do not.
    always_comb begin
        cand         = pc_plus;
        cand_checked = 1'b0;
        advance      = 1'b1;
        if (mret_i) begin
            cand         = epc_i;
            cand_checked = 1'b1;
        end else if (stall_i) begin
            advance      = 1'b0;
        end else if (is_jump) begin
            cand         = jump_tgt;
            cand_checked = 1'b1;
        end else if (is_branch && branch_tkn_i) begin
            cand         = branch_tgt;
            cand_checked = 1'b1;
        end
    end

    assign cand_misaligned = (C_EXT != 0) ? cand[0] : (|cand[1:0]);

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        mis_pulse_next = 1'b0;
        mis_addr_next  = mis_addr;
        unique case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (trap_i) begin
                    pc_next = trap_tgt;
                end else begin
                    if (advance) begin
                        if (cand_checked && cand_misaligned) begin
                            mis_pulse_next = 1'b1;
                            mis_addr_next  = cand;
                        end else begin
                            pc_next = cand;
                        end
                    end
                    if (halt_i) state_next = HALT;
                end
            end
            HALT: begin
                if (trap_i)   pc_next    = trap_tgt;
                if (resume_i) state_next = RUN;
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_ADDR;
            mis_pulse <= 1'b0;
            mis_addr <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            mis_pulse <= mis_pulse_next;
            mis_addr <= mis_addr_next;
        end
    end

    // Misalignment is reported in the cycle the target would have appeared on pc_o.
    assign pc_o              = pc;
    assign pc_plus_o         = pc_plus;
    assign pc_valid_o        = (state == RUN);
    assign halted_o          = (state == HALT);
    assign misaligned_o      = mis_pulse;
    assign misaligned_addr_o = mis_addr;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: one 4-byte-aligned instance and one compressed instance.
module tb_pc_gen;

    localparam logic [1:0] NONE   = 2'b00;
    localparam logic [1:0] JUMP   = 2'b01;
    localparam logic [1:0] BRANCH = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ctrl;
    logic        instr_len;
    logic [31:0] offset;
    logic        branch_tkn;
    logic [31:0] tgt_addr;
    logic        trap;
    logic [31:0] trap_vec;
    logic        mret;
    logic [31:0] epc;
    logic        stall;
    logic        halt;
    logic        resume;

    logic [31:0] pc0, pc_plus0, mis_addr0;
    logic        valid0, mis0, halted0;
    logic [31:0] pc1, pc_plus1, mis_addr1;
    logic        valid1, mis1, halted1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_WIDTH(32), .RESET_ADDR(32'h0001_0074), .C_EXT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ctrl_trans_instr_i(ctrl), .instr_len_i(instr_len),
        .offset_i(offset), .branch_tkn_i(branch_tkn), .tgt_addr_i(tgt_addr),
        .trap_i(trap), .trap_vec_i(trap_vec), .mret_i(mret), .epc_i(epc),
        .stall_i(stall), .halt_i(halt), .resume_i(resume),
        .pc_o(pc0), .pc_plus_o(pc_plus0), .pc_valid_o(valid0),
        .misaligned_o(mis0), .misaligned_addr_o(mis_addr0), .halted_o(halted0)
    );

    pc_gen #(.ADDR_WIDTH(32), .RESET_ADDR(32'h0000_0100), .C_EXT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ctrl_trans_instr_i(ctrl), .instr_len_i(instr_len),
        .offset_i(offset), .branch_tkn_i(branch_tkn), .tgt_addr_i(tgt_addr),
        .trap_i(trap), .trap_vec_i(trap_vec), .mret_i(mret), .epc_i(epc),
        .stall_i(stall), .halt_i(halt), .resume_i(resume),
        .pc_o(pc1), .pc_plus_o(pc_plus1), .pc_valid_o(valid1),
        .misaligned_o(mis1), .misaligned_addr_o(mis_addr1), .halted_o(halted1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] vec);
        trap = 1'b1; trap_vec = vec;
        tick();
        trap = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ctrl = NONE; instr_len = 1'b0; offset = '0; branch_tkn = 1'b0;
        tgt_addr = '0; trap = 1'b0; trap_vec = '0; mret = 1'b0; epc = '0;
        stall = 1'b0; halt = 1'b0; resume = 1'b0;

        #12;
        check("rst_pc", pc0, 32'h10074);
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_mis", 32'(mis0), 32'd0);
        check("rst_mis_addr", mis_addr0, 32'h0);
        check("rst_halted", 32'(halted0), 32'd0);
        rst_n = 1'b1;
        #1;
        check("boot_valid", 32'(valid0), 32'd0);

        tick();
        check("boot_pc_hold", pc0, 32'h10074);
        check("run_valid", 32'(valid0), 32'd1);
        check("c_boot_pc", pc1, 32'h100);

        instr_len = 1'b1;
        #1;
        check("c_pc_plus16", pc_plus1, 32'h102);
        check("pc_plus_len_ignored", pc_plus0, 32'h10078);
        tick();
        check("step1", pc0, 32'h10078);
        check("c_step16_a", pc1, 32'h102);
        tick();
        check("step2", pc0, 32'h1007C);
        check("c_step16_b", pc1, 32'h104);
        instr_len = 1'b0;
        tick();
        check("c_step32", pc1, 32'h108);
        check("step3", pc0, 32'h10080);

        ctrl = JUMP; tgt_addr = 32'h302;
        tick();
        check("jmp_mis_pulse", 32'(mis0), 32'd1);
        check("jmp_mis_addr", mis_addr0, 32'h302);
        check("jmp_mis_pc_hold", pc0, 32'h10080);
        check("c_jmp_ok", pc1, 32'h302);
        check("c_jmp_no_mis", 32'(mis1), 32'd0);

        ctrl = NONE; stall = 1'b1; trap = 1'b1; trap_vec = 32'h803;
        tick();
        check("trap_in_stall", pc0, 32'h800);
        check("mis_pulse_end", 32'(mis0), 32'd0);
        check("mis_addr_held", mis_addr0, 32'h302);
        trap = 1'b0;
        tick();
        check("stall_hold", pc0, 32'h800);
        stall = 1'b0;

        load(32'h200);
        ctrl = BRANCH; branch_tkn = 1'b1; offset = 32'hFFFF_FFF0;
        tick();
        check("br_taken_neg", pc0, 32'h1F0);
        ctrl = NONE;
        load(32'h200);
        ctrl = BRANCH; branch_tkn = 1'b0;
        tick();
        check("br_not_taken", pc0, 32'h204);
        ctrl = NONE;

        load(32'hFFFF_FFFC);
        check("wrap_plus", pc_plus0, 32'h0);
        tick();
        check("wrap_pc", pc0, 32'h0);

        trap = 1'b1; trap_vec = 32'h900; mret = 1'b1; epc = 32'h404; ctrl = JUMP; tgt_addr = 32'h500;
        tick();
        check("prio_trap", pc0, 32'h900);
        trap = 1'b0; ctrl = NONE;
        tick();
        check("mret", pc0, 32'h404);
        stall = 1'b1; epc = 32'h124;
        tick();
        check("mret_in_stall", pc0, 32'h124);
        stall = 1'b0; epc = 32'h126;
        tick();
        check("mret_mis_pulse", 32'(mis0), 32'd1);
        check("mret_mis_addr", mis_addr0, 32'h126);
        check("mret_mis_pc", pc0, 32'h124);
        mret = 1'b0;

        load(32'h600);
        ctrl = JUMP; tgt_addr = 32'h601;
        tick();
        check("jmp_bit0_mask", pc0, 32'h600);
        check("jmp_bit0_no_mis", 32'(mis0), 32'd0);
        ctrl = BRANCH; branch_tkn = 1'b1; offset = 32'h6;
        tick();
        check("br_mis_pulse", 32'(mis0), 32'd1);
        check("br_mis_addr", mis_addr0, 32'h606);
        check("br_mis_pc", pc0, 32'h600);
        offset = 32'h5;
        tick();
        check("br_off_bit0", pc0, 32'h604);
        ctrl = NONE; branch_tkn = 1'b0;

        load(32'h40);
        halt = 1'b1;
        tick();
        check("halt_pc", pc0, 32'h44);
        check("halt_flag", 32'(halted0), 32'd1);
        check("halt_valid", 32'(valid0), 32'd0);
        halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt_hold", pc0, 32'h44);
        end
        resume = 1'b1;
        tick();
        check("resume_flag", 32'(halted0), 32'd0);
        check("resume_valid", 32'(valid0), 32'd1);
        check("resume_pc", pc0, 32'h44);
        resume = 1'b0;
        tick();
        check("resume_step", pc0, 32'h48);

        halt = 1'b1;
        tick();
        halt = 1'b0;
        load(32'hA02);
        check("halt_trap_pc", pc0, 32'hA00);
        check("halt_trap_stay", 32'(halted0), 32'd1);
        halt = 1'b1; resume = 1'b1;
        tick();
        check("resume_wins", 32'(halted0), 32'd0);
        check("resume_wins_pc", pc0, 32'hA00);
        halt = 1'b0; resume = 1'b0;
        tick();
        check("after_resume_step", pc0, 32'hA04);

        halt = 1'b1; trap = 1'b1; trap_vec = 32'hB00;
        tick();
        check("trap_over_halt_pc", pc0, 32'hB00);
        check("trap_over_halt_run", 32'(halted0), 32'd0);
        halt = 1'b0; trap = 1'b0;

        ctrl = JUMP; tgt_addr = 32'h700;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc0, 32'h10074);
        check("async_rst_valid", 32'(valid0), 32'd0);
        tick();
        check("rst_discard", pc0, 32'h10074);
        ctrl = NONE;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program counter and next-PC generator for the toothless fetch stage.
- Adds a configurable reset vector and optional 16-bit (compressed) instruction stepping.
- Adds stall, trap/mret redirect, misaligned-target detection and a halt/resume state machine.
- Sits between decoder/ALU/CSR unit and instruction memory; drives the fetch address and the link address.

Parameters:
- ADDR_WIDTH, 32: width of all address/offset ports, pc_o and pc_plus_o.
- RESET_ADDR, 'h0: value loaded into pc_o on reset.
- C_EXT, 0: 1 enables 16-bit instruction stepping and 2-byte alignment; 0 means 4-byte alignment only.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ctrl_trans_instr_i  in  2  CTRL_TRANS_SEL_NONE/JUMP/BRANCH from toothless_pkg; other codes are treated as NONE.
- instr_len_i  in  1  0 = 32-bit current instruction, 1 = 16-bit; ignored when C_EXT=0.
- offset_i  in  ADDR_WIDTH  branch offset relative to pc_o.
- branch_tkn_i  in  1  branch comparison result from ALU.
- tgt_addr_i  in  ADDR_WIDTH  jump target from ALU.
- trap_i  in  1  trap request from CSR unit.
- trap_vec_i  in  ADDR_WIDTH  trap handler address (mtvec base).
- mret_i  in  1  return from trap.
- epc_i  in  ADDR_WIDTH  return address (mepc).
- stall_i  in  1  hold the PC (fetch/execute not ready).
- halt_i  in  1  request halt.
- resume_i  in  1  leave halt.
- pc_o  out  ADDR_WIDTH  current fetch address.
- pc_plus_o  out  ADDR_WIDTH  link address: pc_o + step (combinational).
- pc_valid_o  out  1  pc_o is a valid fetch address.
- misaligned_o  out  1  one-cycle pulse: computed target is misaligned.
- misaligned_addr_o  out  ADDR_WIDTH  offending target; held until the next misalignment.
- halted_o  out  1  FSM is in HALT.

Behaviour:
- Reset (async assert, sync-to-clk release):
  - pc_o=RESET_ADDR, state=BOOT, pc_valid_o=0, misaligned_o=0, misaligned_addr_o=0, halted_o=0.
  - Reset asserted mid-operation discards any pending update immediately.
- FSM states and transitions:
  - BOOT → RUN unconditionally after one cycle; pc_o unchanged. This gives instruction memory one cycle after reset.
  - RUN: pc_valid_o=1.
    - On halt_i with no trap_i: apply this cycle's update (if advancing), then go to HALT.
  - HALT: pc_valid_o=0, halted_o=1; pc_o holds.
    - resume_i → RUN next cycle.
    - trap_i in HALT loads trap_vec_i (aligned) and stays in HALT.
    - halt_i and resume_i together: resume wins.
- Arithmetic:
  - step = 2 if C_EXT=1 and instr_len_i=1, else 4.
  - All sums are modulo 2^ADDR_WIDTH; wrap-around from the top address to 0 is legal, no flag.
- Next-PC priority in RUN, highest first:
  1. trap_i → trap_vec_i with bits[1:0] forced to 0.
  2. mret_i → epc_i.
  3. JUMP → tgt_addr_i with bit0 forced to 0.
  4. BRANCH with branch_tkn_i=1 → pc_o + offset_i.
  5. Otherwise → pc_o + step (includes BRANCH not taken).
- Stall:
  - trap_i and mret_i apply even when stall_i=1.
  - Priorities 3–5 update pc_o only when stall_i=0.
- Alignment check:
  - Applies to priorities 2–4. Mask is bit1 when C_EXT=0; bit0 can never be set after the jump masking, and for branches bit0 of offset_i is ignored (forced to 0).
  - On misalignment: pc_o not updated, misaligned_o=1 for exactly that cycle, misaligned_addr_o=target.
  - The CSR unit is expected to raise trap_i in a later cycle.
  - Sequential steps never flag.
- Timing:
  - Update latency is one clock: the target is visible on pc_o the cycle after the request.
  - pc_plus_o always reflects the current pc_o and instr_len_i.

Test Plan:
- Reset with RESET_ADDR='h10074 → pc_o='h10074, pc_valid_o=0 for 1 cycle, then 1; with NONE, pc_o='h10078, then 'h1007C.
- C_EXT=1, pc='h100, instr_len_i=1 for 2 cycles then 0 → pc_o='h102, 'h104, 'h108; pc_plus_o='h102 in the first cycle.
- pc='h200, BRANCH with branch_tkn_i=1, offset_i='hFFFFFFF0 → pc_o='h1F0; with branch_tkn_i=0 → 'h204. Then pc='hFFFFFFFC with NONE → pc_o=0.
- C_EXT=0, JUMP with tgt_addr_i='h302 → misaligned_o pulse, misaligned_addr_o='h302, pc_o unchanged. Next cycle stall_i=1 and trap_i=1, trap_vec_i='h803 → pc_o='h800.
- trap_i, mret_i and JUMP asserted in the same cycle → trap wins. Next cycle mret_i, epc_i='h404 → pc_o='h404.
- halt_i at pc='h40 → pc_o='h44, then halted_o=1, pc_valid_o=0, pc_o held for 5 cycles. resume_i → pc_valid_o=1, pc_o advances to 'h48.
